// File: rtl/axi_reg_file_pkg.sv
// Shared types and helpers for the AXI4-Lite register file.
package axi_reg_file_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Expands a byte-strobe vector (up to 8 lanes) into a per-bit mask.
  function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      mask[i*8 +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/axi_reg_file_wr_merge.sv
// Combinational write merge for one register: byte lanes with strobe set take
// the new data, unstrobed lanes and read-only bits keep the old value.
module axi_reg_file_wr_merge
  import axi_reg_file_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_val,
  input  logic [DATA_W-1:0]   new_val,
  input  logic [DATA_W/8-1:0] strb,
  input  logic [DATA_W-1:0]   ro_mask,
  output logic [DATA_W-1:0]   merged
);

  logic [DATA_W-1:0] wr_mask;

  assign wr_mask = DATA_W'(strb_to_mask(8'(strb))) & ~ro_mask;
  assign merged  = (old_val & ~wr_mask) | (new_val & wr_mask);

endmodule

// File: rtl/axi_reg_file.sv
// AXI4-Lite slave register file: NUM_REGS word registers with per-bit reset
// value and read-only mask, byte-strobed writes and per-register write pulses.
// DATA_W must be 32 or 64.
// Optional macro AXI_REG_FILE_SHADOW_EN: writes land in a shadow copy that is
// transferred to o_reg_val when i_commit is asserted.
module axi_reg_file
  import axi_reg_file_pkg::*;
#(
  parameter int                         NUM_REGS    = 3,
  parameter int                         ADDR_W      = 8,
  parameter int                         DATA_W      = 32,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALUE = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RO_MASK     = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_awvalid,
  output logic                         o_awready,
  input  logic [ADDR_W-1:0]            i_awaddr,
  input  logic                         i_wvalid,
  output logic                         o_wready,
  input  logic [DATA_W-1:0]            i_wdata,
  input  logic [DATA_W/8-1:0]          i_wstrb,
  output logic                         o_bvalid,
  input  logic                         i_bready,
  output logic [1:0]                   o_bresp,
  input  logic                         i_arvalid,
  output logic                         o_arready,
  input  logic [ADDR_W-1:0]            i_araddr,
  output logic                         o_rvalid,
  input  logic                         i_rready,
  output logic [DATA_W-1:0]            o_rdata,
  output logic [1:0]                   o_rresp,
  output logic [NUM_REGS*DATA_W-1:0]   o_reg_val,
  input  logic [NUM_REGS*DATA_W-1:0]   i_hw_val,
`ifdef AXI_REG_FILE_SHADOW_EN
  input  logic                         i_commit,
`endif
  output logic [NUM_REGS-1:0]          o_wr_pulse
);

  localparam int                         ADDR_LSB   = $clog2(DATA_W/8);
  localparam logic [ADDR_W-1:0]          NUM_REGS_A = ADDR_W'(NUM_REGS);
  // Only RW bits are stored; RO positions stay zero and are sourced from i_hw_val.
  localparam logic [NUM_REGS*DATA_W-1:0] RESET_RW   = RESET_VALUE & ~RO_MASK;

  logic                       ready_en;
  logic                       aw_held;
  logic                       w_held;
  logic [ADDR_W-1:0]          aw_idx;
  logic [DATA_W-1:0]          w_data;
  logic [DATA_W/8-1:0]        w_strb;
  logic                       bvalid_q;
  axi_resp_e                  bresp_q;
  rd_state_e                  rd_state;
  logic [DATA_W-1:0]          rdata_q;
  axi_resp_e                  rresp_q;
  logic [NUM_REGS*DATA_W-1:0] rw_q;
  logic [NUM_REGS*DATA_W-1:0] rw_next;
  logic [NUM_REGS-1:0]        wr_pulse;
  logic [DATA_W-1:0]          rd_word [NUM_REGS];
  logic [DATA_W-1:0]          rd_sel;
  logic [ADDR_W-1:0]          ar_idx;
  logic                       aw_hs;
  logic                       w_hs;
  logic                       ar_hs;
  logic                       commit;
  logic                       wr_in_range;
  logic                       rd_in_range;

  assign o_awready = ready_en && !aw_held;
  assign o_wready  = ready_en && !w_held;
  assign o_arready = ready_en && (rd_state == R_IDLE);
  assign o_bvalid  = bvalid_q;
  assign o_bresp   = bresp_q;
  assign o_rvalid  = (rd_state == R_DATA);
  assign o_rdata   = rdata_q;
  assign o_rresp   = rresp_q;
  assign o_wr_pulse = wr_pulse;

  assign aw_hs  = i_awvalid && o_awready;
  assign w_hs   = i_wvalid && o_wready;
  assign ar_hs  = i_arvalid && o_arready;
  // A new write may commit once the previous response is gone or leaving now.
  assign commit = aw_held && w_held && (!bvalid_q || i_bready);

  assign wr_in_range = (aw_idx < NUM_REGS_A);
  assign ar_idx      = i_araddr >> ADDR_LSB;
  assign rd_in_range = (ar_idx < NUM_REGS_A);

  // Per-register merge, write pulse and read view.
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    localparam logic [DATA_W-1:0] RO_K = RO_MASK[k*DATA_W +: DATA_W];
    logic [DATA_W-1:0] merged;

    axi_reg_file_wr_merge #(.DATA_W(DATA_W)) u_merge (
      .old_val (rw_q[k*DATA_W +: DATA_W]),
      .new_val (w_data),
      .strb    (w_strb),
      .ro_mask (RO_K),
      .merged  (merged)
    );

    assign wr_pulse[k] = commit && wr_in_range && (aw_idx == ADDR_W'(k));
    assign rw_next[k*DATA_W +: DATA_W] = wr_pulse[k] ? merged : rw_q[k*DATA_W +: DATA_W];
    assign rd_word[k] = rw_q[k*DATA_W +: DATA_W] | (i_hw_val[k*DATA_W +: DATA_W] & RO_K);
  end

  // Read mux over the addressed register.
  always_comb begin
    // NOTE: default first so every path assigns rd_sel and no latch is inferred.
    rd_sel = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (ar_idx == ADDR_W'(k)) rd_sel = rd_word[k];
    end
  end

  // Write channel capture, commit and response; also holds the RW storage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      ready_en <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      // NOTE: the register array is plain flops, so it takes its reset value like any other state.
      rw_q     <= RESET_RW;
    end else begin
      ready_en <= 1'b1;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= i_awaddr >> ADDR_LSB;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= i_wdata;
        w_strb <= i_wstrb;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && i_bready) begin
        bvalid_q <= 1'b0;
      end
      rw_q <= rw_next;
    end
  end

  // Read FSM: sample on AR handshake, hold data until R handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_state <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q  <= rd_in_range ? rd_sel : '0;
            rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (i_rready) rd_state <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

`ifdef AXI_REG_FILE_SHADOW_EN
  logic [NUM_REGS*DATA_W-1:0] live_q;

  // Live copy follows the shadow only when software commits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      live_q <= RESET_RW;
    end else if (i_commit) begin
      live_q <= rw_q;
    end
  end

  assign o_reg_val = live_q;
`else
  assign o_reg_val = rw_q;
`endif

endmodule

// File: tb/tb_axi_reg_file.sv
// Self-checking bench for axi_reg_file: directed cases plus random-stall
// traffic, with B and R expectations queued at issue and compared on handshake.
module tb_axi_reg_file;

  localparam logic [95:0] RST_VAL  = {32'h000F_0000, 32'h0000_0001, 32'h0000_0000};
  localparam logic [95:0] RO_VAL   = {32'h0000_000F, 32'h0000_0000, 32'h0000_0000};
  localparam logic [95:0] INIT_IMG = RST_VAL & ~RO_VAL;

  typedef struct {
    logic [1:0]  resp;
    logic [95:0] img;
  } b_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 1'b0;
  logic [7:0]  awaddr = '0;
  logic        wvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bready = 1'b1;
  logic        arvalid = 1'b0;
  logic [7:0]  araddr = '0;
  logic        rready = 1'b1;
  logic [95:0] hw_val = '0;
  logic        commit = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [95:0] reg_val;
  logic [2:0]  wr_pulse;

  int          n_vec = 0;
  int          n_err = 0;
  int          b_mode = 0;  // 0 ready, 1 stalled, 2 random
  int          r_mode = 0;
  logic [31:0] mdl [3];
  int          exp_pulse [3];
  int          pulse_cnt [3];
  b_exp_t      b_q [$];
  r_exp_t      r_q [$];

  axi_reg_file #(
    .NUM_REGS    (3),
    .ADDR_W      (8),
    .DATA_W      (32),
    .RESET_VALUE (RST_VAL),
    .RO_MASK     (RO_VAL)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_awvalid  (awvalid),
    .o_awready  (awready),
    .i_awaddr   (awaddr),
    .i_wvalid   (wvalid),
    .o_wready   (wready),
    .i_wdata    (wdata),
    .i_wstrb    (wstrb),
    .o_bvalid   (bvalid),
    .i_bready   (bready),
    .o_bresp    (bresp),
    .i_arvalid  (arvalid),
    .o_arready  (arready),
    .i_araddr   (araddr),
    .o_rvalid   (rvalid),
    .i_rready   (rready),
    .o_rdata    (rdata),
    .o_rresp    (rresp),
    .o_reg_val  (reg_val),
    .i_hw_val   (hw_val),
`ifdef AXI_REG_FILE_SHADOW_EN
    .i_commit   (commit),
`endif
    .o_wr_pulse (wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{strb[i]}};
    return m;
  endfunction

  function automatic logic [95:0] model_img();
    return {mdl[2], mdl[1], mdl[0]};
  endfunction

  function automatic int pulse_total();
    return pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2];
  endfunction

  // Ready drivers for the response channels.
  always @(posedge clk) begin
    #1;
    bready = (b_mode == 0) ? 1'b1 : (b_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    rready = (r_mode == 0) ? 1'b1 : (r_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
  end

  // Response monitor: pops expectations on each B/R handshake, counts pulses.
  always @(negedge clk) begin
    b_exp_t be;
    r_exp_t re;
    if (!rst) begin
      for (int k = 0; k < 3; k++) pulse_cnt[k] += int'(wr_pulse[k]);
      if (bvalid && bready) begin
        if (b_q.size() == 0) begin
          check("b_unexpected", 96'(bvalid), 96'(0));
        end else begin
          be = b_q.pop_front();
          check("bresp", 96'(bresp), 96'(be.resp));
`ifndef AXI_REG_FILE_SHADOW_EN
          check("reg_val", reg_val, be.img);
`endif
        end
      end
      if (rvalid && rready) begin
        if (r_q.size() == 0) begin
          check("r_unexpected", 96'(rvalid), 96'(0));
        end else begin
          re = r_q.pop_front();
          check("rdata", 96'(rdata), 96'(re.data));
          check("rresp", 96'(rresp), 96'(re.resp));
        end
      end
    end
  end

  task automatic send_aw(input logic [7:0] addr, input int dly);
    int t = 0;
    @(posedge clk);
    repeat (dly) @(posedge clk);
    #1 awvalid = 1'b1;
    awaddr = addr;
    forever begin
      @(negedge clk);
      if (awready) break;
      if (++t > 100) begin check("aw_timeout", 96'(0), 96'(1)); break; end
    end
    @(posedge clk);
    #1 awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    int t = 0;
    @(posedge clk);
    repeat (dly) @(posedge clk);
    #1 wvalid = 1'b1;
    wdata = data;
    wstrb = strb;
    forever begin
      @(negedge clk);
      if (wready) break;
      if (++t > 100) begin check("w_timeout", 96'(0), 96'(1)); break; end
    end
    @(posedge clk);
    #1 wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [7:0] addr, input int dly);
    int t = 0;
    @(posedge clk);
    repeat (dly) @(posedge clk);
    #1 arvalid = 1'b1;
    araddr = addr;
    forever begin
      @(negedge clk);
      if (arready) break;
      if (++t > 100) begin check("ar_timeout", 96'(0), 96'(1)); break; end
    end
    @(posedge clk);
    #1 arvalid = 1'b0;
  endtask

  // Apply a write to the model and queue its expected response.
  task automatic expect_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    b_exp_t e;
    int idx;
    logic [31:0] m;
    idx = int'(addr >> 2);
    if (idx < 3) begin
      m = lane_mask(strb) & ~RO_VAL[idx*32 +: 32];
      mdl[idx] = (mdl[idx] & ~m) | (data & m);
      exp_pulse[idx]++;
      e.resp = 2'b00;
    end else begin
      e.resp = 2'b10;
    end
    e.img = model_img();
    b_q.push_back(e);
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly);
    expect_write(addr, data, strb);
    fork
      send_aw(addr, aw_dly);
      send_w(data, strb, w_dly);
    join
  endtask

  task automatic drain_b();
    int t = 0;
    while (b_q.size() != 0) begin
      @(negedge clk);
      if (++t > 300) begin check("b_drain_timeout", 96'(b_q.size()), 96'(0)); b_q.delete(); end
    end
  endtask

  task automatic drain_r();
    int t = 0;
    while (r_q.size() != 0) begin
      @(negedge clk);
      if (++t > 300) begin check("r_drain_timeout", 96'(r_q.size()), 96'(0)); r_q.delete(); end
    end
  endtask

  // Reads are issued only after earlier writes have responded.
  task automatic axi_read(input logic [7:0] addr, input int dly);
    r_exp_t e;
    int idx;
    drain_b();
    idx = int'(addr >> 2);
    if (idx < 3) begin
      e.data = mdl[idx] | (hw_val[idx*32 +: 32] & RO_VAL[idx*32 +: 32]);
      e.resp = 2'b00;
    end else begin
      e.data = '0;
      e.resp = 2'b10;
    end
    r_q.push_back(e);
    send_ar(addr, dly);
  endtask

  task automatic wait_bvalid();
    int t = 0;
    do begin
      @(negedge clk);
      if (++t > 50) begin check("bvalid_timeout", 96'(0), 96'(1)); break; end
    end while (!bvalid);
  endtask

  task automatic wait_rvalid();
    int t = 0;
    do begin
      @(negedge clk);
      if (++t > 50) begin check("rvalid_timeout", 96'(0), 96'(1)); break; end
    end while (!rvalid);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  hold_resp;
    logic [31:0] hold_data;
    int          pc;

    for (int k = 0; k < 3; k++) begin
      mdl[k]       = INIT_IMG[k*32 +: 32];
      exp_pulse[k] = 0;
      pulse_cnt[k] = 0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 96'({awready, wready, arready}), 96'(0));
    check("rst_valid", 96'({bvalid, rvalid}), 96'(0));
    check("rst_pulse", 96'(wr_pulse), 96'(0));
    check("rst_reg_val", reg_val, INIT_IMG);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_ready", 96'({awready, wready, arready}), 96'(3'b111));

    // Reset values via reads.
    axi_read(8'h04, 0);
    axi_read(8'h08, 0);
    drain_r();

    // Data before address.
    expect_write(8'h00, 32'hA5A5_A5A5, 4'hF);
    send_w(32'hA5A5_A5A5, 4'hF, 0);
    @(negedge clk);
    check("w_held_ready", 96'(wready), 96'(0));
    send_aw(8'h00, 2);
    @(negedge clk);
    check("commit_pulse", 96'(wr_pulse), 96'(3'b001));
    check("b_before", 96'(bvalid), 96'(0));
    @(negedge clk);
    check("b_after_aw", 96'(bvalid), 96'(1));
    check("pulse_once", 96'(wr_pulse), 96'(0));
    drain_b();

    // Byte strobe and read-only bits; upper hw bits land on RW positions.
    hw_val = {32'hABCD_1239, 32'h5555_5555, 32'hAAAA_AAAA};
    axi_write(8'h08, 32'hFFFF_FFFF, 4'b0010, 0, 0);
    axi_read(8'h08, 0);
    axi_read(8'h06, 0);
    drain_r();

    // Out of range.
    drain_b();
    pc = pulse_total();
    axi_write(8'h0C, 32'hDEAD_BEEF, 4'hF, 0, 0);
    axi_read(8'h10, 0);
    drain_r();
    check("oor_no_pulse", 96'(pulse_total()), 96'(pc));

    // Zero-strobe write still pulses.
    pc = pulse_cnt[1];
    axi_write(8'h04, 32'hFFFF_FFFF, 4'h0, 1, 0);
    drain_b();
    check("zero_strb_pulse", 96'(pulse_cnt[1]), 96'(pc + 1));
    axi_read(8'h04, 0);
    drain_r();

    // B backpressure: second write stays held until B completes.
    b_mode = 1;
    axi_write(8'h04, 32'hCAFE_0001, 4'hF, 0, 0);
    wait_bvalid();
    hold_resp = bresp;
    axi_write(8'h01, 32'h0BAD_0002, 4'h3, 0, 1);
    pc = pulse_total();
    repeat (5) begin
      @(negedge clk);
      check("b_hold_valid", 96'(bvalid), 96'(1));
      check("b_hold_resp", 96'(bresp), 96'(hold_resp));
      check("aw_blocked", 96'(awready), 96'(0));
    end
    check("no_commit_stall", 96'(pulse_total()), 96'(pc));
    b_mode = 0;
    drain_b();

    // R backpressure.
    r_mode = 1;
    axi_read(8'h04, 0);
    wait_rvalid();
    hold_data = rdata;
    repeat (5) begin
      @(negedge clk);
      check("r_hold_valid", 96'(rvalid), 96'(1));
      check("r_hold_data", 96'(rdata), 96'(hold_data));
      check("ar_blocked", 96'(arready), 96'(0));
    end
    r_mode = 0;
    drain_r();

    // Random traffic with random stalls.
    b_mode = 2;
    r_mode = 2;
    for (int n = 0; n < 20; n++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 19));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(a, $urandom_range(0, 2));
    end
    drain_b();
    drain_r();
    b_mode = 0;
    r_mode = 0;
    for (int k = 0; k < 3; k++) check("pulse_count", 96'(pulse_cnt[k]), 96'(exp_pulse[k]));

`ifdef AXI_REG_FILE_SHADOW_EN
    // Shadow: live copy moves only on commit.
    axi_write(8'h00, 32'h0000_1234, 4'hF, 0, 0);
    drain_b();
    @(negedge clk);
    check("shadow_hold", reg_val, INIT_IMG);
    @(posedge clk);
    #1 commit = 1'b1;
    @(posedge clk);
    #1 commit = 1'b0;
    @(negedge clk);
    check("shadow_commit", reg_val, model_img());
`endif

    // Reset with a write address pending: nothing responds afterwards.
    send_aw(8'h00, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) mdl[k] = INIT_IMG[k*32 +: 32];
    repeat (4) begin
      @(negedge clk);
      check("no_b_after_rst", 96'(bvalid), 96'(0));
    end
    check("rst_reg_restore", reg_val, INIT_IMG);
    axi_read(8'h04, 0);
    drain_r();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
